// File: rtl/soc2_uart_rx_fifo.sv
// Receive-side byte FIFO between the UART receiver and the peripheral register block.
// Stores {ferr, data} per byte, first-word-fall-through head, sticky overrun, threshold irq.
module soc2_uart_rx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  input  logic          rx_ferr,
  input  logic          rd_pop,
  output logic [7:0]    rd_data,
  output logic          rd_ferr,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overrun,
  input  logic          clr_overrun,
  input  logic [AW:0]   irq_thresh,
  output logic          irq
);

  localparam logic [AW:0] DepthCnt = (AW + 1)'(DEPTH);

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overrun_q, overrun_d;
  logic          irq_q, irq_d;

  logic          do_push;
  logic          do_pop;
  logic          drop;
  logic [8:0]    head;

  assign empty = (count_q == '0);
  assign full  = (count_q == DepthCnt);

  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  assign do_pop  = rd_pop && !empty;
  assign do_push = rx_valid && (!full || rd_pop);
  assign drop    = rx_valid && full && !rd_pop;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (do_pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    overrun_d = overrun_q;
    if (drop) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end
  end

  always_comb begin
    irq_d = (irq_thresh != '0) && (count_d >= irq_thresh);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      irq_q     <= irq_d;
    end
  end

  // Storage is deliberately not reset; empty gating hides stale entries.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr_q] <= {rx_ferr, rx_data};
    end
  end

  always_comb begin
    head = empty ? 9'h000 : mem[rptr_q];
  end

  assign rd_data = head[7:0];
  assign rd_ferr = head[8];
  assign count   = count_q;
  assign overrun = overrun_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_soc2_uart_rx_fifo.sv
// Randomised scoreboard bench for soc2_uart_rx_fifo: queue model for contents, arithmetic
// model for count/flags, and a negedge monitor that checks every popped head.
module tb_soc2_uart_rx_fifo;

  localparam int D = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ferr;
  logic       rd_pop;
  logic [7:0] rd_data;
  logic       rd_ferr;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overrun;
  logic       clr_overrun;
  logic [4:0] irq_thresh;
  logic       irq;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];
  int         m_cnt;
  bit         m_over;
  bit         m_irq;

  soc2_uart_rx_fifo #(.DEPTH(16), .AW(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ferr     (rx_ferr),
    .rd_pop      (rd_pop),
    .rd_data     (rd_data),
    .rd_ferr     (rd_ferr),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .overrun     (overrun),
    .clr_overrun (clr_overrun),
    .irq_thresh  (irq_thresh),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted CPU read must return the oldest model entry.
  always @(negedge clk) begin
    if (!reset && rd_pop) begin
      if (exp_q.size() > 0) begin
        chk("pop_head", {23'd0, rd_ferr, rd_data}, {23'd0, exp_q.pop_front()});
      end else begin
        chk("pop_empty", {22'd0, empty, rd_ferr, rd_data}, 32'h200);
      end
    end
  end

  task automatic chk_status(input string tag);
    chk({tag, "_count"}, {27'd0, count}, m_cnt);
    chk({tag, "_empty"}, {31'd0, empty}, (m_cnt == 0));
    chk({tag, "_full"}, {31'd0, full}, (m_cnt == D));
    chk({tag, "_overrun"}, {31'd0, overrun}, {31'd0, m_over});
    chk({tag, "_irq"}, {31'd0, irq}, {31'd0, m_irq});
    if (m_cnt == 0) chk({tag, "_head0"}, {23'd0, rd_ferr, rd_data}, 32'd0);
    else            chk({tag, "_head"}, {23'd0, rd_ferr, rd_data}, {23'd0, exp_q[0]});
  endtask

  // Drive one cycle starting just after a posedge; model advances on the next posedge.
  task automatic cycle(input bit v, input logic [7:0] d, input bit f, input bit p, input bit c,
                       input string tag);
    int  old_cnt;
    bit  acc_pop, acc_push;
    rx_valid = v; rx_data = d; rx_ferr = f; rd_pop = p; clr_overrun = c;
    old_cnt = m_cnt;
    @(posedge clk);
    acc_pop  = p && (old_cnt > 0);
    acc_push = v && ((old_cnt < D) || p);
    if (acc_push) exp_q.push_back({f, d});
    m_cnt = old_cnt + int'(acc_push) - int'(acc_pop);
    if (v && old_cnt == D && !p) m_over = 1'b1;
    else if (c)                  m_over = 1'b0;
    m_irq = (irq_thresh != 0) && (m_cnt >= int'(irq_thresh));
    #1;
    rx_valid = 1'b0; rd_pop = 1'b0; clr_overrun = 1'b0;
    chk_status(tag);
  endtask

  task automatic push(input logic [7:0] d, input bit f);
    cycle(1'b1, d, f, 1'b0, 1'b0, "push");
  endtask

  task automatic pop();
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "pop");
  endtask

  task automatic drain();
    while (m_cnt > 0) pop();
  endtask

  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    exp_q.delete();
    m_cnt = 0; m_over = 1'b0; m_irq = 1'b0;
    chk_status(tag);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rx_ferr = 1'b0;
    rd_pop = 1'b0; clr_overrun = 1'b0; irq_thresh = 5'd0;
    m_cnt = 0; m_over = 1'b0; m_irq = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_status("reset");

    push(8'h07, 1'b0);
    pop();

    // Fill, then overflow with 8'h5A which must never be read.
    for (int i = 0; i < 16; i++) push(i[7:0], 1'b0);
    push(8'h5A, 1'b0);
    drain();
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "clr");

    // Push and pop together while full: accepted, no overrun.
    for (int i = 0; i < 16; i++) push(8'h80 + i[7:0], 1'b0);
    cycle(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, "full_pushpop");
    drain();

    // Push and pop together while empty: push wins.
    cycle(1'b1, 8'h11, 1'b0, 1'b1, 1'b0, "empty_pushpop");
    drain();

    push(8'h33, 1'b1);
    push(8'h44, 1'b0);
    drain();

    irq_thresh = 5'd4;
    for (int i = 0; i < 4; i++) push(8'h20 + i[7:0], 1'b0);
    pop();
    drain();
    irq_thresh = 5'd0;
    for (int i = 0; i < 16; i++) push(8'h60 + i[7:0], 1'b1);
    drain();
    irq_thresh = 5'd17;
    for (int i = 0; i < 16; i++) push(8'h70 + i[7:0], 1'b0);
    drain();

    // Randomised interleaving with occasional threshold changes and clears.
    for (int i = 0; i < 300; i++) begin
      if ((i % 37) == 0) irq_thresh = 5'($urandom_range(0, 17));
      cycle(($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom),
            ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 5), "rand");
    end
    drain();

    // Mid-operation asynchronous reset with five bytes buffered.
    irq_thresh = 5'd3;
    for (int i = 0; i < 5; i++) push(8'hC0 + i[7:0], 1'b0);
    async_reset("midreset");
    push(8'h99, 1'b0);
    drain();

    // Clear coincident with a dropping push: set wins.
    irq_thresh = 5'd0;
    for (int i = 0; i < 16; i++) push(8'hD0 + i[7:0], 1'b0);
    push(8'hEE, 1'b0);
    cycle(1'b1, 8'hEF, 1'b0, 1'b0, 1'b1, "clr_vs_set");
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "clr_only");
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/soc2_uart_rx_fifo.md
# soc2_uart_rx_fifo

Receive-side byte buffer between the UART receiver (`urx`) and the peripheral register interface in `u_peri`. It captures each byte the receiver completes, together with its framing-error flag, into a 16-entry FIFO. It exposes the oldest entry to CPU reads in first-word-fall-through form. It reports fill level, sticky overrun and a threshold interrupt so the CPU can drain bursts without polling every byte.

## Interface
Parameters:
- `DEPTH`, 16, FIFO entries; must be a power of two, minimum 2.
- `AW`, 4, pointer width, equal to log2(`DEPTH`).

Ports:
- `clk`  in  1  core clock, same domain as `u_peri`.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_valid`  in  1  one-cycle pulse: `urx` has completed a byte.
- `rx_data`  in  8  received byte, qualified by `rx_valid`.
- `rx_ferr`  in  1  framing error (stop bit low) for this byte, qualified by `rx_valid`.
- `rd_pop`  in  1  CPU read strobe of the data register; pops the head entry.
- `rd_data`  out  8  head byte (FWFT); 8'h00 when empty.
- `rd_ferr`  out  1  framing-error flag of the head entry; 0 when empty.
- `empty`  out  1  FIFO holds no entries.
- `full`  out  1  FIFO holds `DEPTH` entries.
- `count`  out  AW+1  number of entries held, 0..`DEPTH`.
- `overrun`  out  1  sticky: a byte was dropped because the FIFO was full.
- `clr_overrun`  in  1  one-cycle pulse that clears `overrun`.
- `irq_thresh`  in  AW+1  interrupt threshold; 0 disables the interrupt.
- `irq`  out  1  level interrupt, registered.

## Operation
- Storage: `DEPTH` x 9-bit array holding {ferr, data}. Write pointer `wptr` and read pointer `rptr` are AW bits wide and wrap modulo `DEPTH`. `count` is a separate AW+1-bit register.
- Push: `rx_valid` && !`full` writes {`rx_ferr`, `rx_data`} at `wptr`, then `wptr`+1.
- Pop: `rd_pop` && !`empty` advances `rptr`+1. The entry is not cleared.
- Count update: push only gives +1, pop only gives −1. Push and pop together leave `count` unchanged.
- `empty` = (`count`==0) and `full` = (`count`==`DEPTH`). Both derive from the registered `count`.
- `rd_data` and `rd_ferr` are driven from the array at `rptr`, gated to 0 when `empty`.
- Overrun: `rx_valid` && `full` && !`rd_pop` drops the byte and sets `overrun`.
- `rx_valid` && `full` && `rd_pop` is not an overrun. The pop frees a slot and the push is accepted in the same cycle, so `count` stays at `DEPTH`.
- Push and pop while empty: the push is accepted, the pop is ignored, and `count` becomes 1.
- `rd_pop` while empty: no effect on pointers, `count` or flags.
- `clr_overrun` clears `overrun`. If a set condition occurs in the same cycle, the set wins and `overrun` stays 1.
- `irq` is registered: next `irq` = (`irq_thresh`!=0) && (next `count` >= `irq_thresh`). A threshold above `DEPTH` never fires.
- Reset: `wptr`=0, `rptr`=0, `count`=0, `overrun`=0, `irq`=0. Consequently `empty`=1, `full`=0, `rd_data`=0 and `rd_ferr`=0. Array contents are not reset.
- Reset during a transfer discards all buffered bytes. A `rx_valid` coincident with the reset release edge is ignored.

## Timing
- Push latency: when `rx_valid` is sampled at edge N, `count`, `empty`, `full`, `rd_data` and `rd_ferr` reflect the new entry after edge N.
- Pop latency: when `rd_pop` is sampled at edge N, the next head appears on `rd_data` after edge N. The CPU samples the old head in the same cycle it asserts `rd_pop`.
- `irq` changes after the same edge as `count`, because it is computed from next-count, not from the registered `count`.
- `overrun` sets after the edge on which the drop occurs.
- No backpressure toward `urx`: `rx_valid` is never stalled. At most one push and one pop occur per cycle.

## Test plan
- Reset, then push 8'h07 (ferr=0) -> after the edge, `empty`=0, `count`=1, `rd_data`=8'h07. Then pop -> `empty`=1, `rd_data`=8'h00.
- Push 16 bytes 8'h00..8'h0F, then push 8'h5A -> `full`=1, `overrun`=1, `count`=16. Pop all 16 -> data 8'h00..8'h0F in order, 8'h5A never appears.
- With the FIFO full, push 8'hA5 and pop in the same cycle -> `overrun` stays 0, `count`=16, and 8'hA5 is the 16th entry read.
- Push 8'h33 with `rx_ferr`=1, then 8'h44 with `rx_ferr`=0 -> `rd_ferr` reads 1 then 0, paired with the correct bytes.
- `irq_thresh`=4: push 3 bytes -> `irq`=0. Push a 4th -> `irq`=1 after that edge. Pop 1 -> `irq`=0. With `irq_thresh`=0, 16 pushes -> `irq` stays 0.
- Pointer wrap plus mid-operation reset:
  - Run 40 interleaved push/pop cycles and check the data order against a model queue.
  - Assert `reset` with `count`=5 -> `count`=0, `empty`=1 and `overrun`=0 immediately.
  - Set `overrun`, then pulse `clr_overrun` in the same cycle as a full-drop push -> `overrun` remains 1.
